// File: rtl/image_scaler_engine.sv
// image_scaler_engine: replicate-zoom / decimate / block-average scaler
// between a fixed-latency source memory and a back-pressured frame buffer.
module image_scaler_engine #(
  parameter int PIX_W  = 8,
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int RA_W   = 15,
  parameter int WA_W   = 20,
  parameter int RD_LAT = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ABORT,
  input  logic [1:0]       MODE,
  input  logic [1:0]       SCALE_LOG2,
  output logic             RD_EN,
  output logic [RA_W-1:0]  R_ADDR,
  input  logic [PIX_W-1:0] PIXEL_IN,
  output logic             WR_VALID,
  input  logic             WR_READY,
  output logic [WA_W-1:0]  W_ADDR,
  output logic [PIX_W-1:0] PIXEL_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int AW = PIX_W + 4;
  localparam int CW = $clog2(4 * (SRC_W + SRC_H) + 1);
  localparam int LW = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WT,
    S_WR,
    S_DONE
  } state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [1:0]      s_q;
  logic [1:0]      tx;
  logic [1:0]      ty;
  logic [CW-1:0]   x;
  logic [CW-1:0]   y;
  logic [CW-1:0]   out_w;
  logic [CW-1:0]   out_h;
  logic [AW-1:0]   acc;
  logic [LW-1:0]   cnt;
  logic [WA_W-1:0] waddr;
  logic            done_q;
  logic            err_q;

  logic [CW-1:0] sx;
  logic [CW-1:0] sy;
  logic [CW-1:0] src_w;
  logic [CW-1:0] src_h;
  logic [1:0]    tmax;
  logic          last_tap;
  logic          last_x;
  logic          last_y;
  logic          illegal;

  assign src_w = CW'(SRC_W);
  assign src_h = CW'(SRC_H);

  assign illegal = (MODE == 2'b11) ||
                   (SCALE_LOG2 == 2'd0) ||
                   (SCALE_LOG2 == 2'd3);

  always_comb begin
    sx = x;
    sy = y;
    unique case (mode_q)
      2'b00: begin
        sx = x >> s_q;
        sy = y >> s_q;
      end
      2'b01: begin
        sx = x << s_q;
        sy = y << s_q;
      end
      default: begin
        sx = (x << s_q) + CW'(tx);
        sy = (y << s_q) + CW'(ty);
      end
    endcase
  end

  assign tmax     = (s_q == 2'd1) ? 2'd1 : 2'd3;
  assign last_tap = (mode_q != 2'b10) ||
                    ((tx == tmax) && (ty == tmax));
  assign last_x   = (x == out_w - CW'(1));
  assign last_y   = (y == out_h - CW'(1));

  // Strobes drop in the abort cycle itself so nothing leaks out.
  assign RD_EN    = (state == S_RD) && !ABORT;
  assign WR_VALID = (state == S_WR) && !ABORT;
  assign BUSY     = (state == S_RD) ||
                    (state == S_WT) ||
                    (state == S_WR);
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign W_ADDR   = waddr;
  assign R_ADDR   = RA_W'(sy) * RA_W'(SRC_W) + RA_W'(sx);

  assign PIXEL_OUT = (mode_q == 2'b10) ?
                     PIX_W'(acc >> {s_q, 1'b0}) :
                     PIX_W'(acc);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= S_IDLE;
      mode_q <= 2'b00;
      s_q    <= 2'b00;
      tx     <= 2'b00;
      ty     <= 2'b00;
      x      <= '0;
      y      <= '0;
      out_w  <= '0;
      out_h  <= '0;
      acc    <= '0;
      cnt    <= '0;
      waddr  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (ABORT && state != S_IDLE) begin
      state  <= S_IDLE;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START) begin
            mode_q <= MODE;
            s_q    <= SCALE_LOG2;
            done_q <= 1'b0;
            if (illegal) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              err_q <= 1'b0;
              x     <= '0;
              y     <= '0;
              tx    <= 2'b00;
              ty    <= 2'b00;
              acc   <= '0;
              waddr <= '0;
              if (MODE == 2'b00) begin
                out_w <= src_w << SCALE_LOG2;
                out_h <= src_h << SCALE_LOG2;
              end else begin
                out_w <= src_w >> SCALE_LOG2;
                out_h <= src_h >> SCALE_LOG2;
              end
              state <= S_RD;
            end
          end
        end
        S_RD: begin
          cnt   <= LW'(RD_LAT);
          state <= S_WT;
        end
        S_WT: begin
          if (cnt == LW'(1)) begin
            acc <= acc + AW'(PIXEL_IN);
            if (last_tap) begin
              state <= S_WR;
            end else begin
              if (tx == tmax) begin
                tx <= 2'b00;
                ty <= ty + 2'd1;
              end else begin
                tx <= tx + 2'd1;
              end
              state <= S_RD;
            end
          end else begin
            cnt <= cnt - LW'(1);
          end
        end
        S_WR: begin
          if (WR_READY) begin
            acc   <= '0;
            tx    <= 2'b00;
            ty    <= 2'b00;
            waddr <= waddr + WA_W'(1);
            if (last_x) begin
              x <= '0;
              if (last_y) begin
                done_q <= 1'b1;
                state  <= S_DONE;
              end else begin
                y     <= y + CW'(1);
                state <= S_RD;
              end
            end else begin
              x     <= x + CW'(1);
              state <= S_RD;
            end
          end
        end
        S_DONE: begin
          if (!START) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
